// File: rtl/tone_gen.sv
// Square-wave note generator; optional one-deep note queue under TONE_GEN_QUEUE_EN.
// Latency: CNT_W divider cycles before a tone starts, done one cycle after the last PLAY cycle.
// Backpressure: ready low while the engine (or pending slot) is occupied; starts not accepted are dropped.
module tone_gen #(
  parameter int CLK_HZ = 10000000,
  parameter int FREQ_W = 9,
  parameter int CNT_W  = 24,
  parameter int DUR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUR_W-1:0]  dur_ms,
  input  logic              stop,
  output logic              wave,
  output logic              busy,
  output logic              ready,
  output logic              done
);
  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int BIT_W  = $clog2(CNT_W);
  // CLK_HZ is even, so (CLK_HZ/2)/freq equals CLK_HZ/(2*freq) and fits in CNT_W bits
  localparam logic [CNT_W-1:0] HALF_DIVIDEND = CNT_W'(CLK_HZ / 2);
  localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(MS_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(CNT_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, PLAY} state_t;

  state_t            state;
  logic [FREQ_W-1:0] freq_q;
  logic [DUR_W-1:0]  dur_q;
  logic [FREQ_W-1:0] rem;
  logic [CNT_W-1:0]  quo;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [PRE_W-1:0]  pre;
  logic [DUR_W-1:0]  ms_left;

  logic              accept;
  logic              last_play;
  logic              launch;
  logic [FREQ_W-1:0] l_freq;
  logic [DUR_W-1:0]  l_dur;
  logic [FREQ_W:0]   trial;
  logic              trial_ge;
  logic [FREQ_W-1:0] rem_nxt;
  logic [CNT_W-1:0]  quo_nxt;
  logic [CNT_W-1:0]  half_m1;

`ifdef TONE_GEN_QUEUE_EN
  logic              pend_vld;
  logic [FREQ_W-1:0] pend_freq;
  logic [DUR_W-1:0]  pend_dur;
  assign ready = ~pend_vld;
`else
  assign ready = (state == IDLE);
`endif

  assign busy      = (state != IDLE);
  assign accept    = start & ready & ~stop;
  assign last_play = (state == PLAY) && (pre == PRE_LAST) && (ms_left == DUR_W'(1));
  assign half_m1   = quo - CNT_W'(1);

  // One restoring step: dividend bits leave quo at the top, quotient bits enter at the bottom
  assign trial    = {rem, quo[CNT_W-1]};
  assign trial_ge = (trial >= {1'b0, freq_q});
  assign rem_nxt  = trial_ge ? FREQ_W'(trial - {1'b0, freq_q}) : trial[FREQ_W-1:0];
  assign quo_nxt  = {quo[CNT_W-2:0], trial_ge};

  always_comb begin
    launch = 1'b0;
    l_freq = freq;
    l_dur  = dur_ms;
    if (state == IDLE) begin
      launch = accept;
    end
`ifdef TONE_GEN_QUEUE_EN
    else if (last_play && !stop) begin
      if (pend_vld) begin
        launch = 1'b1;
        l_freq = pend_freq;
        l_dur  = pend_dur;
      end else begin
        launch = accept;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wave    <= 1'b0;
      done    <= 1'b0;
      freq_q  <= '0;
      dur_q   <= '0;
      rem     <= '0;
      quo     <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      pre     <= '0;
      ms_left <= '0;
`ifdef TONE_GEN_QUEUE_EN
      pend_vld  <= 1'b0;
      pend_freq <= '0;
      pend_dur  <= '0;
`endif
    end else if (stop) begin
      state   <= IDLE;
      wave    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      cnt     <= '0;
      pre     <= '0;
      ms_left <= '0;
`ifdef TONE_GEN_QUEUE_EN
      pend_vld <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            if (quo_nxt == '0) quo <= CNT_W'(1);
            state   <= PLAY;
            cnt     <= '0;
            pre     <= '0;
            ms_left <= dur_q;
            wave    <= 1'b0;
          end
        end
        PLAY: begin
          if (freq_q != '0) begin
            if (cnt == half_m1) begin
              cnt  <= '0;
              wave <= ~wave;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (pre == PRE_LAST) begin
            pre     <= '0;
            ms_left <= ms_left - 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
          if (last_play) begin
            state <= IDLE;
            wave  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase

      // A launch overrides the completion path so a queued note follows with no IDLE gap
      if (launch) begin
        freq_q  <= l_freq;
        dur_q   <= l_dur;
        rem     <= '0;
        quo     <= HALF_DIVIDEND;
        bit_cnt <= '0;
        cnt     <= '0;
        pre     <= '0;
        ms_left <= l_dur;
        wave    <= 1'b0;
        if (l_dur == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (l_freq == '0) begin
          state <= PLAY;
        end else begin
          state <= CALC;
        end
      end

`ifdef TONE_GEN_QUEUE_EN
      if (last_play) begin
        pend_vld <= 1'b0;
      end else if (accept && busy) begin
        pend_vld  <= 1'b1;
        pend_freq <= freq;
        pend_dur  <= dur_ms;
      end
`endif
    end
  end
endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: notes are pushed on issue, a negedge monitor checks each note's
// busy length and wave sequence at its done pulse against an arithmetic model.
module tb_tone_gen;
  localparam int CLK_HZ   = 8000;
  localparam int FREQ_W   = 13;
  localparam int CNT_W    = 13;
  localparam int DUR_W    = 12;
  localparam int CALC_CYC = CNT_W;
  localparam int MS_CYC   = CLK_HZ / 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [FREQ_W-1:0] freq;
  logic [DUR_W-1:0]  dur_ms;
  logic              wave;
  logic              busy;
  logic              ready;
  logic              done;

  int total = 0;
  int bad   = 0;
  int idle_wave_bad = 0;

  typedef struct {
    int f;
    int d;
    bit busy_at_done;
  } note_t;

  note_t sb[$];
  bit    got[$];
  note_t mon_n;
  int    mon_mism;

  tone_gen #(
    .CLK_HZ(CLK_HZ),
    .FREQ_W(FREQ_W),
    .CNT_W (CNT_W),
    .DUR_W (DUR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .freq  (freq),
    .dur_ms(dur_ms),
    .stop  (stop),
    .wave  (wave),
    .busy  (busy),
    .ready (ready),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic int note_len(int f, int d);
    if (d == 0) return 0;
    return ((f != 0) ? CALC_CYC : 0) + d * MS_CYC;
  endfunction

  function automatic int half_of(int f);
    int h;
    h = CLK_HZ / (2 * f);
    return (h == 0) ? 1 : h;
  endfunction

  // Wave level on the i-th busy cycle of a note: silent while dividing, then a square wave
  function automatic bit exp_wave(int f, int i);
    int k;
    if (f == 0 || i < CALC_CYC) return 1'b0;
    k = i - CALC_CYC;
    return ((k / half_of(f)) % 2) == 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got a done pulse, expected none outstanding");
        end else begin
          mon_n    = sb.pop_front();
          mon_mism = 0;
          check("note_len", got.size(), note_len(mon_n.f, mon_n.d));
          for (int i = 0; i < got.size(); i++)
            if (got[i] !== exp_wave(mon_n.f, i)) mon_mism++;
          check("wave_seq", mon_mism, 0);
          check("busy_at_done", busy, mon_n.busy_at_done);
        end
        got.delete();
      end else if (busy !== 1'b1) begin
        got.delete();
      end
      if (busy === 1'b1) got.push_back(wave);
      else if (wave !== 1'b0) idle_wave_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (!(ready === 1'b1 && busy === 1'b0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL wait_free: got ready=%b busy=%b, expected idle within 500 cycles", ready, busy);
    end
  endtask

  task automatic issue(int f, int d, bit expect_done);
    freq   = FREQ_W'(f);
    dur_ms = DUR_W'(d);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    freq   = FREQ_W'($urandom);
    dur_ms = DUR_W'($urandom);
    if (expect_done) sb.push_back('{f, d, 1'b0});
  endtask

  task automatic abort_check(string tag);
    check({tag, "_wave"},  wave,  0);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_done"},  done,  0);
    check({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; freq = '0; dur_ms = '0;
    repeat (2) @(posedge clk);
    #1;
    abort_check("reset");
    tick();
    rst = 1'b0;

    wait_free(); issue(1000, 2, 1);
    wait_free(); issue(0, 3, 1);
    wait_free(); issue(700, 0, 1);
    check("zero_dur_busy", busy, 0);
    wait_free(); issue(5000, 1, 1);

    // Stop during PLAY cycle 10 of a 500 Hz note
    wait_free(); issue(500, 4, 0);
    repeat (CALC_CYC + 10 - 1) tick();
    check("wave_before_stop", wave, exp_wave(500, CALC_CYC + 10));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    abort_check("stop");
    repeat (40) tick();

    // Reset mid-CALC and mid-PLAY (rest note)
    wait_free(); issue(700, 2, 0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 abort_check("rst_calc");
    tick(); rst = 1'b0;
    repeat (40) tick();
    wait_free(); issue(0, 2, 0);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 abort_check("rst_play");
    tick(); rst = 1'b0;
    repeat (30) tick();

`ifndef TONE_GEN_QUEUE_EN
    wait_free(); issue(1000, 2, 1);
    repeat (CALC_CYC + 3) tick();
    check("ready_while_busy", ready, 0);
    freq = FREQ_W'(2000); dur_ms = DUR_W'(1); start = 1'b1;
    tick();
    start = 1'b0;
`else
    wait_free(); issue(1000, 2, 0);
    sb.push_back('{1000, 2, 1'b1});
    repeat (CALC_CYC + 3) tick();
    check("ready_before_queue", ready, 1);
    freq = FREQ_W'(2000); dur_ms = DUR_W'(1); start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back('{2000, 1, 1'b0});
    check("ready_after_queue", ready, 0);
    freq = FREQ_W'(300); dur_ms = DUR_W'(2); start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    check("queue_busy_at_done", busy, 1);
    tick();
    n = 1;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    check("queue_gap", n, CALC_CYC + MS_CYC);
`endif

    for (int k = 0; k < 40; k++) begin
      int f, d, len, j;
      bit do_stop;
      f = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8191));
      d = int'($urandom_range(0, 3));
      len = note_len(f, d);
      do_stop = (len >= 2) && ($urandom_range(0, 3) == 0);
      wait_free();
      issue(f, d, !do_stop);
      if (do_stop) begin
        j = int'($urandom_range(1, len - 1));
        repeat (j - 1) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("rand_stop_busy", busy, 0);
      end
`ifndef TONE_GEN_QUEUE_EN
      else if (len >= 3 && $urandom_range(0, 1) == 1) begin
        tick();
        freq = FREQ_W'($urandom); dur_ms = DUR_W'($urandom); start = 1'b1;
        tick();
        start = 1'b0;
      end
`endif
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin tick(); n++; end
    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    check("idle_wave_violations", idle_wave_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
